// File: rtl/cordic_ctl.sv
// Sequencing controller for an iterative CORDIC datapath: latches the operands,
// steps the datapath through NUM_ITER iterations under a watchdog, and hands the results to the host.
module cordic_ctl #(
    parameter int NUM_ITER      = 8,
    parameter int TIMEOUT_SLACK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode_in,
    input  logic [7:0] arg0,
    input  logic [7:0] arg1,
    output logic       in_ready,
    output logic       busy,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res0,
    output logic [7:0] res1,
    output logic       err,
    output logic       cordic_mode,
    output logic [7:0] in_port0,
    output logic [7:0] in_port1,
    output logic [1:0] in_mux_ctl,
    output logic       counter_rst,
    output logic       counter_hold,
    input  logic [3:0] counter,
    input  logic [7:0] out_port0,
    input  logic [7:0] out_port1
);

    typedef enum logic [2:0] {IDLE, LOAD, ITER, DRAIN, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(NUM_ITER - 1);
    // Compared against the pre-increment value: the increment in this cycle reaches the limit.
    localparam logic [4:0] WD_LAST  = 5'(NUM_ITER + TIMEOUT_SLACK - 1);

    state_t     state_q, state_d;
    logic       mode_q, mode_d;
    logic [7:0] port0_q, port0_d, port1_q, port1_d;
    logic [7:0] res0_q, res0_d, res1_q, res1_d;
    logic       err_q, err_d;
    logic [4:0] wdog_q, wdog_d;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        port0_d      = port0_q;
        port1_d      = port1_q;
        res0_d       = res0_q;
        res1_d       = res1_q;
        err_d        = err_q;
        wdog_d       = wdog_q;
        in_ready     = 1'b0;
        busy         = 1'b0;
        res_valid    = 1'b0;
        in_mux_ctl   = 2'b11;
        counter_rst  = 1'b0;
        counter_hold = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready    = 1'b1;
                counter_rst = 1'b1;
                if (start) begin
                    mode_d  = mode_in;
                    port0_d = arg0;
                    port1_d = arg1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy        = 1'b1;
                in_mux_ctl  = mode_q ? 2'b10 : 2'b00;
                counter_rst = 1'b1;
                wdog_d      = 5'd0;
                state_d     = ITER;
            end
            ITER: begin
                busy       = 1'b1;
                in_mux_ctl = 2'b01;
                wdog_d     = wdog_q + 5'd1;
                // Normal completion wins if it coincides with the timeout.
                if (counter == LAST_CNT) begin
                    state_d = DRAIN;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy         = 1'b1;
                counter_hold = 1'b1;
                res0_d       = out_port0;
                res1_d       = out_port1;
                state_d      = DONE;
            end
            DONE: begin
                res_valid    = 1'b1;
                counter_hold = 1'b1;
                if (res_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            port0_q <= 8'h00;
            port1_q <= 8'h00;
            res0_q  <= 8'h00;
            res1_q  <= 8'h00;
            err_q   <= 1'b0;
            wdog_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            port0_q <= port0_d;
            port1_q <= port1_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
        end
    end

    assign cordic_mode = mode_q;
    assign in_port0    = port0_q;
    assign in_port1    = port1_q;
    assign res0        = res0_q;
    assign res1        = res1_q;
    assign err         = err_q;

endmodule

// File: tb/tb_cordic_ctl.sv
// Directed bench for cordic_ctl: a behavioural iteration counter and datapath stand-in,
// with expected results queued at start and checked when res_valid appears.
module tb_cordic_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] r1;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // DUT A: default parameters
    logic       rst = 1'b1, start = 1'b0, mode_in = 1'b0, res_ready = 1'b0;
    logic [7:0] arg0 = 8'h00, arg1 = 8'h00;
    logic       in_ready, busy, res_valid, err, cordic_mode, counter_rst, counter_hold;
    logic [7:0] res0, res1, in_port0, in_port1, out_port0, out_port1;
    logic [1:0] in_mux_ctl;
    logic [3:0] cnt = 4'd0;
    logic       tie_cnt = 1'b0;

    // DUT B: single iteration
    logic       start_b = 1'b0, mode_b = 1'b0, res_ready_b = 1'b0;
    logic [7:0] arg0_b = 8'h00, arg1_b = 8'h00;
    logic       in_ready_b, busy_b, res_valid_b, err_b, cordic_mode_b, counter_rst_b, counter_hold_b;
    logic [7:0] res0_b, res1_b, in_port0_b, in_port1_b, out_port0_b, out_port1_b;
    logic [1:0] in_mux_ctl_b;
    logic [3:0] cnt_b = 4'd0;

    cordic_ctl #(.NUM_ITER(8), .TIMEOUT_SLACK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .arg0(arg0), .arg1(arg1),
        .in_ready(in_ready), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res0(res0), .res1(res1), .err(err), .cordic_mode(cordic_mode),
        .in_port0(in_port0), .in_port1(in_port1), .in_mux_ctl(in_mux_ctl),
        .counter_rst(counter_rst), .counter_hold(counter_hold), .counter(cnt),
        .out_port0(out_port0), .out_port1(out_port1)
    );

    cordic_ctl #(.NUM_ITER(1), .TIMEOUT_SLACK(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode_in(mode_b), .arg0(arg0_b), .arg1(arg1_b),
        .in_ready(in_ready_b), .busy(busy_b), .res_valid(res_valid_b), .res_ready(res_ready_b),
        .res0(res0_b), .res1(res1_b), .err(err_b), .cordic_mode(cordic_mode_b),
        .in_port0(in_port0_b), .in_port1(in_port1_b), .in_mux_ctl(in_mux_ctl_b),
        .counter_rst(counter_rst_b), .counter_hold(counter_hold_b), .counter(cnt_b),
        .out_port0(out_port0_b), .out_port1(out_port1_b)
    );

    // Datapath stand-in: iteration counter plus an output that depends on the final count.
    always @(posedge clk) begin
        if (tie_cnt || counter_rst) cnt <= 4'd0;
        else if (!counter_hold)     cnt <= cnt + 4'd1;
        if (counter_rst_b)          cnt_b <= 4'd0;
        else if (!counter_hold_b)   cnt_b <= cnt_b + 4'd1;
    end
    assign out_port0   = in_port0 + 8'(cnt) * 8'd3;
    assign out_port1   = in_port1 ^ {4'h0, cnt};
    assign out_port0_b = in_port0_b + 8'(cnt_b) * 8'd3;
    assign out_port1_b = in_port1_b ^ {4'h0, cnt_b};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Runs one operation on DUT A from an IDLE negedge until res_valid, optionally
    // pulsing start while busy. Leaves the DUT in DONE.
    task automatic do_op(input logic m, input logic [7:0] a0, input logic [7:0] a1,
                         input int exp_lat, input int exp_iters, input bit pulse);
        int   lat, iters;
        bit   stable;
        logic [7:0] c;
        exp_t e, got;
        c = tie_cnt ? 8'd0 : 8'd8;
        e.r0 = a0 + c * 8'd3;
        e.r1 = a1 ^ c;
        e.err = tie_cnt;
        sb.push_back(e);
        start = 1'b1; mode_in = m; arg0 = a0; arg1 = a1;
        lat = 0; iters = 0; stable = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = pulse && (cyc % 2 == 0);
            mode_in = ~m; arg0 = ~a0; arg1 = ~a1;
            if (cyc == 1) begin
                check("load_mux", 32'(in_mux_ctl), m ? 32'd2 : 32'd0);
                check("load_busy", 32'(busy), 32'd1);
            end
            if (in_mux_ctl === 2'b01) iters++;
            if (cordic_mode !== m || in_port0 !== a0 || in_port1 !== a1 || in_ready !== 1'b0)
                stable = 1'b0;
            if (res_valid === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("iter_cycles", 32'(iters), 32'(exp_iters));
        check("operands_stable", 32'(stable), 32'd1);
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("res0", 32'(res0), 32'(got.r0));
            check("res1", 32'(res1), 32'(got.r1));
            check("err", 32'(err), 32'(got.err));
        end else begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end
    endtask

    task automatic release_result(input logic [7:0] keep0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("rel_valid", 32'(res_valid), 32'd0);
        check("rel_ready", 32'(in_ready), 32'd1);
        check("rel_err", 32'(err), 32'd0);
        check("rel_res0_kept", 32'(res0), 32'(keep0));
    endtask

    initial begin
        int  iters, lat;
        bit  stable;
        // Reset with start asserted: reset wins.
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_res", {16'h0, res0, res1}, 32'd0);
        check("rst_ports", {15'h0, cordic_mode, in_port0, in_port1}, 32'd0);
        check("rst_mux", 32'(in_mux_ctl), 32'd3);
        check("rst_cnt_ctl", {30'h0, counter_rst, counter_hold}, 32'd2);

        // Rotation, nominal latency.
        do_op(1'b0, 8'h20, 8'h00, 11, 8, 1'b0);
        release_result(8'h38);

        // res_ready while idle is ignored.
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_rr_valid", 32'(res_valid), 32'd0);
        check("idle_rr_ready", 32'(in_ready), 32'd1);

        // Vectoring with start pulsed while busy, then back-pressure in DONE.
        do_op(1'b1, 8'h40, 8'hC0, 11, 8, 1'b1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            @(negedge clk);
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
                res0 !== 8'h58 || res1 !== 8'hC8 || in_port0 !== 8'h40)
                stable = 1'b0;
        end
        check("backpressure_stable", 32'(stable), 32'd1);
        // start together with res_ready in DONE: back to IDLE, start not taken.
        start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; res_ready = 1'b0;
        check("done_start_idle", {30'h0, in_ready, busy}, 32'd2);
        @(negedge clk);
        check("done_start_not_taken", {30'h0, in_ready, busy}, 32'd2);
        check("done_res0_kept", 32'(res0), 32'h58);

        // Timeout: counter stuck at zero.
        tie_cnt = 1'b1;
        do_op(1'b0, 8'h5A, 8'h33, 15, 12, 1'b0);
        check("timeout_valid", 32'(res_valid), 32'd1);
        tie_cnt = 1'b0;
        release_result(8'h5A);

        // Reset during the 4th ITER cycle.
        start = 1'b1; mode_in = 1'b1; arg0 = 8'h11; arg1 = 8'h22;
        iters = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (in_mux_ctl === 2'b01) iters++;
            if (iters == 4) break;
        end
        check("midop_reached_iter4", 32'(iters), 32'd4);
        rst = 1'b1; start = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; res_ready = 1'b0;
        check("midop_in_ready", 32'(in_ready), 32'd1);
        check("midop_busy", 32'(busy), 32'd0);
        check("midop_cnt_rst", 32'(counter_rst), 32'd1);
        check("midop_valid", 32'(res_valid), 32'd0);
        check("midop_res", {16'h0, res0, res1}, 32'd0);
        check("midop_ports", {15'h0, cordic_mode, in_port0, in_port1}, 32'd0);
        @(negedge clk);
        check("midop_rst_start_ignored", 32'(busy), 32'd0);

        do_op(1'b0, 8'h07, 8'hF0, 11, 8, 1'b0);
        release_result(8'h1F);

        // Single-iteration instance.
        start_b = 1'b1; mode_b = 1'b0; arg0_b = 8'h10; arg1_b = 8'h01;
        lat = 0; iters = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (in_mux_ctl_b === 2'b01) iters++;
            if (res_valid_b === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        check("n1_latency", 32'(lat), 32'd4);
        check("n1_iter_cycles", 32'(iters), 32'd1);
        check("n1_res", {16'h0, res0_b, res1_b}, 32'h1300);
        check("n1_err", 32'(err_b), 32'd0);
        res_ready_b = 1'b1;
        @(negedge clk);
        res_ready_b = 1'b0;
        check("n1_release", {30'h0, in_ready_b, res_valid_b}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cordic_ctl.md
CORDIC_CTL -- requirements
Module: cordic_ctl

Interface
REQ-001 Parameter NUM_ITER, default 8, SHALL set the iteration count per operation; legal range is 1..15.
REQ-002 Parameter TIMEOUT_SLACK, default 4, SHALL set the extra cycles allowed beyond NUM_ITER before an error is declared.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  host request; qualified only when in_ready=1.
REQ-006 mode_in  in  1  0=rotation (theta in arg0), 1=vectoring (x in arg0, y in arg1).
REQ-007 arg0 / arg1  in  8 each  host operands, sampled when start&in_ready.
REQ-008 in_ready  out  1  controller accepts a new operation.
REQ-009 busy  out  1  operation in progress (LOAD, ITER, DRAIN).
REQ-010 res_valid  out  1  results res0/res1/err are valid.
REQ-011 res_ready  in  1  host consumes the result.
REQ-012 res0 / res1  out  8 each  captured datapath out_port0 / out_port1.
REQ-013 err  out  1  set when the iteration timeout fired for this result.
REQ-014 cordic_mode  out  1  latched mode to the datapath.
REQ-015 in_port0 / in_port1  out  8 each  latched operands to the datapath.
REQ-016 in_mux_ctl  out  2  datapath input select: 00=rotation load, 10=vectoring load, 01=recirculate, 11=hold.
REQ-017 counter_rst / counter_hold  out  1 each  datapath iteration counter controls.
REQ-018 counter  in  4  datapath iteration index.
REQ-019 out_port0 / out_port1  in  8 each  datapath results.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, ITER, DRAIN and DONE, and SHALL be in IDLE after reset.
REQ-021 IDLE outputs SHALL be in_ready=1, in_mux_ctl=11, counter_rst=1, counter_hold=0.
REQ-022 In IDLE, start=1 SHALL latch mode_in, arg0 and arg1 into cordic_mode, in_port0 and in_port1, and move to LOAD on the next edge.
REQ-023 LOAD SHALL last exactly 1 cycle, with in_mux_ctl=00 when cordic_mode=0 and 10 when cordic_mode=1, counter_rst=1, then move to ITER.
REQ-024 ITER outputs SHALL be in_mux_ctl=01, counter_rst=0, counter_hold=0.
REQ-025 ITER SHALL move to DRAIN on the edge where counter==NUM_ITER-1 is sampled.
REQ-026 An internal 5-bit watchdog SHALL clear on LOAD and increment each ITER cycle.
REQ-027 If the watchdog reaches NUM_ITER+TIMEOUT_SLACK while in ITER, the FSM SHALL set err=1 and move to DRAIN.
REQ-028 DRAIN SHALL last 1 cycle with counter_hold=1 and in_mux_ctl=11, capture out_port0/out_port1 into res0/res1, and move to DONE.
REQ-029 DONE SHALL assert res_valid=1 with res0, res1 and err held stable, and SHALL move to IDLE on the edge where res_ready=1.
REQ-030 Leaving DONE SHALL clear res_valid and err, while res0/res1 retain their values until the next capture.
REQ-031 in_ready SHALL be 1 only in IDLE, and start in any other state SHALL be ignored without side effects.
REQ-032 busy SHALL be 1 exactly in LOAD, ITER and DRAIN.
REQ-033 cordic_mode, in_port0 and in_port1 SHALL remain constant from latch until the next accepted start.
REQ-034 res_ready while res_valid=0 SHALL be ignored.
REQ-035 Nominal start-accept to res_valid latency SHALL be NUM_ITER+3 cycles (LOAD + NUM_ITER×ITER + DRAIN, then DONE).
REQ-036 With NUM_ITER=1, ITER SHALL last 1 cycle (counter==0 sampled).
REQ-037 start and res_ready high in the same DONE cycle SHALL return the FSM to IDLE, with start not accepted until the following IDLE cycle.

Reset
REQ-038 rst=1 SHALL, on the next edge and from any state including mid-ITER, force IDLE.
REQ-039 After that reset edge the outputs SHALL be in_ready=1, busy=0, res_valid=0, err=0, and res0=res1=0x00.
REQ-040 After that reset edge the datapath controls SHALL be cordic_mode=0, in_port0=in_port1=0x00, in_mux_ctl=11, counter_rst=1, counter_hold=0, and the watchdog SHALL be 0.
REQ-041 rst SHALL take priority over start and res_ready in the same cycle.

Verification
REQ-042 Rotation: NUM_ITER=8, start with mode_in=0, arg0=0x20, counter model incrementing from 0 -> LOAD shows in_mux_ctl=00; 8 ITER cycles with in_mux_ctl=01; res_valid at cycle 11 after accept; res0/res1 equal the model out_ports in DRAIN; err=0.
REQ-043 Vectoring: mode_in=1, arg0=0x40, arg1=0xC0 -> LOAD shows in_mux_ctl=10, in_port0=0x40, in_port1=0xC0, cordic_mode=1 for the whole operation.
REQ-044 Timeout: counter tied at 0 -> DRAIN entered after 12 ITER cycles (8+4); err=1 with res_valid; err clears after res_ready.
REQ-045 Back-pressure and ignore: res_ready held 0 for 20 cycles in DONE, with start pulsed during busy and DONE -> res0/res1/res_valid stable; no second operation begins; in_ready=0 throughout.
REQ-046 Reset mid-op: rst asserted at the 4th ITER cycle -> next cycle IDLE with in_ready=1, counter_rst=1, res_valid=0, res0=res1=0x00; a subsequent start completes normally.
REQ-047 Edge case: NUM_ITER=1 -> accept-to-res_valid latency of 4 cycles.
